// File: rtl/i2c_pkg.sv
// Shared I2C types and constants for the target responder and the APB bridge.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned I2C_CNT_W  = 3;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    WR_NACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_tgt_state_e;

  function automatic logic addr_match(input logic [I2C_ADDR_W-1:0] rx_addr,
                                      input logic [I2C_ADDR_W-1:0] own_addr);
    return rx_addr == own_addr;
  endfunction

endpackage

// File: rtl/i2c_target_responder_if.sv
// Pin-level and byte-stream signals of the I2C target responder.
interface i2c_target_responder_if;
  import i2c_pkg::*;

  logic                  scl_in;
  logic                  sda_in;
  logic                  sda_oe;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_ack;
  logic                  addressed;
  logic                  busy;

  modport master (
    output scl_in, sda_in, rx_ready, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_ack, addressed, busy
  );

  modport slave (
    input  scl_in, sda_in, rx_ready, tx_data,
    output sda_oe, rx_data, rx_valid, tx_ack, addressed, busy
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with registered edge, START and STOP pulses.
// Pin-to-event latency is SYNC_STAGES+1 clocks; sda_s is aligned with the pulses.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] scl_sync;
  logic [NS-1:0] sda_sync;
  logic          scl_s;
  logic          scl_now;
  logic          sda_now;

  assign scl_now = scl_sync[NS-1];
  assign sda_now = sda_sync[NS-1];

  // Idle bus is pulled high, so reset to 1 to avoid spurious events.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_s     <= 1'b1;
      sda_s     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[NS-2:0], scl_in};
      sda_sync  <= {sda_sync[NS-2:0], sda_in};
      scl_s     <= scl_now;
      sda_s     <= sda_now;
      scl_rise  <= scl_now & ~scl_s;
      scl_fall  <= ~scl_now & scl_s;
      // SCL must be high on both samples so an SCL edge never fakes START/STOP.
      start_det <= scl_now & scl_s & ~sda_now & sda_s;
      stop_det  <= scl_now & scl_s & sda_now & ~sda_s;
    end
  end

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: address match, write bytes to rx stream, read bytes from tx stream.
// SDA is only ever pulled low; SCL is never stretched.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h55,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input logic                   PCLK,
  input logic                   PRESET,
  i2c_target_responder_if.slave bus
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (PCLK),
    .rst      (PRESET),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_tgt_state_e        state;
  logic [I2C_CNT_W-1:0]  bit_cnt;
  logic [I2C_BYTE_W-1:0] shift;
  logic [I2C_BYTE_W-1:0] byte_in;
  logic                  phase;
  logic                  rd_mode;

  assign byte_in = {shift[I2C_BYTE_W-2:0], sda_s};

  // phase: in *_ACK, 1 once the ACK is being driven; in RD_DATA, 1 while
  // waiting for the first scl_fall before driving the MSB.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      phase         <= 1'b0;
      rd_mode       <= 1'b0;
      bus.sda_oe    <= 1'b0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.tx_ack    <= 1'b0;
      bus.addressed <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.tx_ack   <= 1'b0;
      if (stop_det) begin
        state         <= IDLE;
        bus.sda_oe    <= 1'b0;
        bus.addressed <= 1'b0;
        bus.busy      <= 1'b0;
      end else if (start_det) begin
        state         <= ADDR;
        bit_cnt       <= '0;
        bus.sda_oe    <= 1'b0;
        bus.addressed <= 1'b0;
        bus.busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (addr_match(byte_in[I2C_BYTE_W-1:1], TARGET_ADDR)) begin
                  state         <= ADDR_ACK;
                  phase         <= 1'b0;
                  bus.addressed <= 1'b1;
                  rd_mode       <= (sda_s == I2C_RW_READ);
                  if (sda_s == I2C_RW_READ) begin
                    shift      <= bus.tx_data;
                    bus.tx_ack <= 1'b1;
                  end
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                bus.sda_oe <= 1'b1;
                phase      <= 1'b1;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= '0;
                if (state == ADDR_ACK && rd_mode) begin
                  state      <= RD_DATA;
                  bus.sda_oe <= ~shift[I2C_BYTE_W-1];
                end else begin
                  state      <= WR_DATA;
                  bus.sda_oe <= 1'b0;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                phase <= 1'b0;
                if (bus.rx_ready) begin
                  bus.rx_data  <= byte_in;
                  bus.rx_valid <= 1'b1;
                  state        <= WR_ACK;
                end else begin
                  state <= WR_NACK;
                end
              end
            end
          end
          WR_NACK: begin
            if (scl_fall) begin
              bus.sda_oe <= 1'b0;
              state      <= WAIT_STOP;
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              shift   <= {shift[I2C_BYTE_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (phase) begin
                bus.sda_oe <= ~shift[I2C_BYTE_W-1];
                phase      <= 1'b0;
              end else if (bit_cnt == 3'd0) begin
                bus.sda_oe <= 1'b0;
                state      <= RD_ACK;
              end else begin
                bus.sda_oe <= ~shift[I2C_BYTE_W-1];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_ACK) begin
                shift      <= bus.tx_data;
                bus.tx_ack <= 1'b1;
                bit_cnt    <= '0;
                phase      <= 1'b1;
                state      <= RD_DATA;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          WAIT_STOP: bus.sda_oe <= 1'b0;
          default: begin
            state      <= IDLE;
            bus.sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench: bit-banged I2C master with a queue/array reference of expected bus traffic.
module tb_i2c_target_responder;
  import i2c_pkg::*;

  localparam int unsigned Q   = 6;
  localparam logic [6:0]  TGT = 7'h55;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic rdy = 1'b1;

  logic [7:0] tx_buf [0:63];
  int         tx_idx = 0;
  logic [7:0] wr_buf [0:7];
  logic [7:0] exp_rx [$];
  logic [7:0] rx_got [$];
  int         rx_chk = 0;
  int         total = 0;
  int         bad = 0;

  i2c_target_responder_if bus();

  assign bus.scl_in   = scl_m;
  assign bus.sda_in   = sda_m & ~bus.sda_oe;
  assign bus.rx_ready = rdy;
  assign bus.tx_data  = tx_buf[6'(tx_idx)];

  i2c_target_responder #(.TARGET_ADDR(TGT), .SYNC_STAGES(2)) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte sink records every write; byte source advances on each capture.
  always @(posedge clk) begin
    if (bus.rx_valid) rx_got.push_back(bus.rx_data);
    if (bus.tx_ack) tx_idx <= tx_idx + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One SCL clock: master drives b (1 = release), returns the wired-AND line.
  task automatic bit_w(input logic b, output logic line);
    tick(Q); sda_m = b;
    tick(Q); scl_m = 1'b1;
    tick(Q); line = bus.sda_in;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      tick(Q); sda_m = 1'b1;
      tick(Q); scl_m = 1'b1;
      tick(Q);
    end else begin
      sda_m = 1'b1;
      tick(Q);
    end
    sda_m = 1'b0;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); sda_m = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) bit_w(d[i], l);
    bit_w(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      bit_w(1'b1, l);
      d[i] = l;
    end
    bit_w(mack, l);
  endtask

  task automatic wr_txn(input logic [6:0] a, input int n, input logic ready, input logic do_stop);
    logic ack;
    logic alive;
    rdy = ready;
    i2c_start();
    write_byte({a, 1'b0}, ack);
    alive = (a == TGT);
    check("addr_ack", 32'(ack), alive ? 32'd0 : 32'd1);
    check("busy_in_txn", 32'(bus.busy), 32'd1);
    check("addressed_in_txn", 32'(bus.addressed), 32'(alive));
    for (int i = 0; i < n; i++) begin
      write_byte(wr_buf[i], ack);
      check("data_ack", 32'(ack), (alive && ready) ? 32'd0 : 32'd1);
      if (alive && ready) exp_rx.push_back(wr_buf[i]);
      else alive = 1'b0;
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic rd_txn(input int n);
    logic       ack;
    logic [7:0] d;
    int         base;
    base = tx_idx;
    i2c_start();
    write_byte({TGT, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      check("rd_byte", 32'(d), 32'(tx_buf[6'(base + i)]));
    end
    tick(2);
    check("rd_wait_stop", 32'(dut.state), 32'(WAIT_STOP));
    i2c_stop();
    tick(4);
    check("tx_ack_count", 32'(tx_idx - base), 32'(n));
  endtask

  task automatic end_check();
    tick(10);
    check("busy_after_stop", 32'(bus.busy), 32'd0);
    check("addressed_after_stop", 32'(bus.addressed), 32'd0);
    check("state_idle", 32'(dut.state), 32'(IDLE));
    check("rx_count", 32'(rx_got.size()), 32'(exp_rx.size()));
    for (int i = rx_chk; i < exp_rx.size() && i < rx_got.size(); i++)
      check("rx_byte", 32'(rx_got[i]), 32'(exp_rx[i]));
    rx_chk = exp_rx.size();
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_sda_oe"}, 32'(bus.sda_oe), 32'd0);
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_tx_ack"}, 32'(bus.tx_ack), 32'd0);
    check({tag, "_addressed"}, 32'(bus.addressed), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    check({tag, "_bit_cnt"}, 32'(dut.bit_cnt), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic       l;
    logic       seen;
    logic [7:0] d;
    int         n;
    int         base;
    logic [6:0] a;

    for (int i = 0; i < 64; i++) tx_buf[i] = 8'($urandom);
    tick(4);
    reset_values("reset");
    rst = 1'b0;
    tick(4);

    // Two-byte write, both accepted
    wr_buf[0] = 8'hA5; wr_buf[1] = 8'h3C;
    wr_txn(TGT, 2, 1'b1, 1'b1);
    end_check();

    // Two-byte read, master ACK then NACK
    tx_buf[6'(tx_idx)] = 8'h96; tx_buf[6'(tx_idx + 1)] = 8'h0F;
    rd_txn(2);
    end_check();

    // Foreign address stays silent but bus is busy until STOP
    wr_buf[0] = 8'hFF;
    wr_txn(7'h2A, 1, 1'b1, 1'b0);
    check("foreign_busy", 32'(bus.busy), 32'd1);
    check("foreign_addressed", 32'(bus.addressed), 32'd0);
    i2c_stop();
    end_check();

    // Sink not ready: NACK, following byte ignored
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
    wr_txn(TGT, 2, 1'b0, 1'b1);
    end_check();

    // Partial byte then repeated START into a read
    rdy = 1'b1;
    i2c_start();
    write_byte({TGT, 1'b0}, ack);
    check("rs_addr_ack", 32'(ack), 32'd0);
    for (int k = 0; k < 4; k++) bit_w(1'($urandom), l);
    i2c_start();
    tick(2);
    check("rs_addressed_cleared", 32'(bus.addressed), 32'd0);
    check("rs_busy", 32'(bus.busy), 32'd1);
    base = tx_idx;
    tx_buf[6'(base)] = 8'hC3;
    write_byte({TGT, 1'b1}, ack);
    check("rs_rd_addr_ack", 32'(ack), 32'd0);
    read_byte(1'b1, d);
    check("rs_rd_byte", 32'(d), 32'hC3);
    i2c_stop();
    check("rs_tx_ack_count", 32'(tx_idx - base), 32'd1);
    end_check();

    // Randomized writes, sometimes to a foreign address or a stalled sink
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : TGT;
      wr_txn(a, n, ($urandom_range(0, 3) != 0), 1'b1);
      end_check();
    end

    // Randomized reads
    for (int r = 0; r < 3; r++) begin
      rd_txn($urandom_range(1, 3));
      end_check();
    end

    // Reset while the target pulls SDA low for a read 0-bit
    tx_buf[6'(tx_idx)] = 8'h3C;
    i2c_start();
    write_byte({TGT, 1'b1}, ack);
    check("prst_addr_ack", 32'(ack), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      seen = bus.sda_oe;
    end
    check("prst_drive_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    tick(1);
    reset_values("prst");
    check("prst_line_released", 32'(bus.sda_in), 32'd1);
    rst = 1'b0;
    tick(4);
    i2c_stop();
    wr_buf[0] = 8'($urandom);
    wr_txn(TGT, 1, 1'b1, 1'b1);
    end_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- Synthesizable I2C target (slave) at the far end of the bus driven by apb_i2c_bridge.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, then receives write bytes to a byte-stream output, or transmits read bytes from a byte-stream input.
- Replaces the behavioural I2C responder process in benches and serves as a reusable on-chip target.

Parameters:
- TARGET_ADDR, 7'h55, 7-bit address this target answers to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (min 2).

Ports:
- PCLK  in  1  system clock; must be ≥8x SCL rate.
- PRESET  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL level (pulled-up bus).
- sda_in  in  1  raw SDA level.
- sda_oe  out  1  1 = pull SDA low; top ties sda = sda_oe ? 1'b0 : 1'bz.
- rx_data  out  8  last byte written by the master.
- rx_valid  out  1  one-PCLK pulse, rx_data is new.
- rx_ready  in  1  sink can accept a byte; sampled at 8th data bit; 0 ⇒ NACK.
- tx_data  in  8  byte to return on a read.
- tx_ack  out  1  one-PCLK pulse, tx_data captured; source presents the next byte.
- addressed  out  1  high from address ACK until STOP or repeated START.
- busy  out  1  high between START and STOP (any address).

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, tx_ack=0, addressed=0, busy=0, FSM=IDLE, bit_cnt=0.
- Sampling: scl_s/sda_s are the synchronized signals plus one history flop.
  - scl_rise/scl_fall are edges of scl_s.
  - START = sda_s falls while scl_s=1; STOP = sda_s rises while scl_s=1.
- Timing: data is sampled on scl_rise. sda_oe changes only on the PCLK after scl_fall, which gives hold time. Latency from raw pin to internal event is SYNC_STAGES+1 PCLKs.
- Bit counter: bit_cnt is 3 bits, MSB first, reset to 0 on entering any byte state. The byte is complete when bit_cnt wraps 7→0.
- FSM states and transitions:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - Address match → ADDR_ACK.
    - Mismatch → WAIT_STOP; sda_oe stays 0.
  - ADDR_ACK: set sda_oe=1 after the scl_fall that ends bit 8, and release it after the next scl_fall. Set addressed=1.
    - R/W=0 → WR_DATA.
    - R/W=1 → RD_DATA; latch tx_data into the shift register at ACK entry and pulse tx_ack.
  - WR_DATA: shift 8 bits.
    - At the 8th scl_rise: rx_ready=1 → load rx_data, pulse rx_valid, go to WR_ACK.
    - At the 8th scl_rise: rx_ready=0 → go to WR_NACK; no rx_valid.
  - WR_ACK: drive 0 for one SCL period, then → WR_DATA.
  - WR_NACK: release SDA, then → WAIT_STOP.
  - RD_DATA: drive sda_oe = ~shift[7] after each scl_fall, shift on scl_rise. After 8 bits, release SDA → RD_ACK.
  - RD_ACK: sample master SDA on scl_rise.
    - 0 (ACK) → latch tx_data, pulse tx_ack, → RD_DATA.
    - 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: sda_oe=0; → IDLE on STOP, → ADDR on START.
- Global overrides (priority over all of the above):
  - STOP in any state → IDLE, sda_oe=0, addressed=0.
  - START (repeated) in any state → ADDR, sda_oe=0, addressed=0.
  - If a START/STOP coincides with a scl edge on the same PCLK, START/STOP wins.
- busy: set on START, cleared on STOP.
- Reset mid-transfer: PRESET forces all reset values on the next PCLK; SDA is released immediately.
- Arbitration: the target never stretches SCL (no SCL output).

Decomposition:
- Shared package i2c_pkg holds:
  - enum i2c_tgt_state_e {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, WR_NACK, RD_DATA, RD_ACK, WAIT_STOP};
  - constants I2C_RW_READ=1'b1, I2C_ACK=1'b0.
- One sub-module: i2c_bus_sync, which contains the synchronizers plus the scl_rise, scl_fall, start_det and stop_det pulses. It is reused by the bridge.

Test Plan:
- Write 0x55+W, data 0xA5, 0x3C, STOP, rx_ready=1 → ACK on all 3 bytes; rx_valid pulses twice with 0xA5 then 0x3C; addressed falls after STOP; busy=0.
- Read 0x55+R, tx_data=0x96 then 0x0F, master ACK then NACK, STOP → bus carries 0x96, 0x0F MSB first; tx_ack pulses twice; FSM reaches WAIT_STOP then IDLE.
- Address 0x2A+W, data 0xFF → no ACK (SDA high at bit 9); rx_valid never pulses; addressed stays 0; busy=1 until STOP.
- Write 0x55+W, byte 0x11 with rx_ready=0 → NACK at bit 9; no rx_valid; next byte ignored; IDLE after STOP.
- Write 0x55+W, 4 bits of data, then repeated START, 0x55+R, tx_data=0xC3 → partial byte discarded, re-addressed, 0xC3 returned.
- Assert PRESET while the target drives a read 0-bit → sda_oe=0 on the next PCLK; all outputs at reset values; next START+0x55+W ACKed normally.
